// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle SRL/SLL/SRA/ROR shifter, at most STEP positions per clock
// Optional SEQ_SHIFTER_STATUS_EN adds carry-out (C) and zero (Z) status outputs.
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int MW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [MW-1:0]    mag,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q
`ifdef SEQ_SHIFTER_STATUS_EN
   ,
   output logic             C,
   output logic             Z
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [1:0] OP_SRL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [MW-1:0] STEP_V = MW'(STEP);

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [1:0]       r_op;
   logic [MW-1:0]    r_rem;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [MW-1:0]    w_n;
   logic [WIDTH-1:0] w_shifted;
   logic [MW-1:0]    w_out_idx;

   assign w_n = (r_rem < STEP_V) ? r_rem : STEP_V;

   // ROR needs w_n >= 1, which always holds while in SHIFT.
   always_comb begin
      w_shifted = r_q;
      case (r_op)
         OP_SRL:  w_shifted = r_q >> w_n;
         OP_SLL:  w_shifted = r_q << w_n;
         OP_SRA:  w_shifted = WIDTH'($signed(r_q) >>> w_n);
         default: w_shifted = (r_q >> w_n) | (r_q << (WIDTH - int'(w_n)));
      endcase
   end

   // Index of the last bit leaving Q this step; wraps harmlessly when w_n is 0.
   assign w_out_idx = (r_op == OP_SLL) ? MW'(WIDTH - int'(w_n)) : (w_n - 1'b1);

`ifdef SEQ_SHIFTER_STATUS_EN
   logic r_c;
   logic r_z;
   assign C = r_c;
   assign Z = r_z;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_q         <= '0;
         r_op        <= OP_SRL;
         r_rem       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef SEQ_SHIFTER_STATUS_EN
         r_c         <= 1'b0;
         r_z         <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_q        <= A;
                  r_op       <= op;
                  r_rem      <= mag;
                  r_in_ready <= 1'b0;
`ifdef SEQ_SHIFTER_STATUS_EN
                  r_c        <= 1'b0;
                  r_z        <= (A == '0);
`endif
                  if (mag == '0) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_q   <= w_shifted;
               r_rem <= r_rem - w_n;
`ifdef SEQ_SHIFTER_STATUS_EN
               r_c   <= r_q[w_out_idx];
               r_z   <= (w_shifted == '0);
`endif
               if (r_rem <= STEP_V) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign Q         = r_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized and directed bench for seq_shifter, STEP=1 and STEP=4 instances
// Define SEQ_SHIFTER_STATUS_EN to also check the C/Z status outputs.
module tb_seq_shifter;
   localparam int W  = 16;
   localparam int MW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  a = '0;
   logic [MW-1:0] mag = '0;
   logic [1:0]    op = '0;
   logic          out_ready = 1'b0;
   logic          in_ready1, out_valid1, in_ready4, out_valid4;
   logic [W-1:0]  q1, q4;
`ifdef SEQ_SHIFTER_STATUS_EN
   logic          c1, z1, c4, z4;
`endif

   int total = 0;
   int bad   = 0;

   seq_shifter #(.WIDTH(W), .STEP(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .A(a), .mag(mag), .op(op), .out_valid(out_valid1), .out_ready(out_ready), .Q(q1)
`ifdef SEQ_SHIFTER_STATUS_EN
      , .C(c1), .Z(z1)
`endif
   );

   seq_shifter #(.WIDTH(W), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .A(a), .mag(mag), .op(op), .out_valid(out_valid4), .out_ready(out_ready), .Q(q4)
`ifdef SEQ_SHIFTER_STATUS_EN
      , .C(c4), .Z(z4)
`endif
   );

   // Reference: shifts as arithmetic on integers (divide/multiply by powers of two).
   function automatic logic [W-1:0] ref_q(input logic [W-1:0] x, input int m, input logic [1:0] o);
      longint v, d, sv, r;
      v = longint'(x);
      d = longint'(1) << m;
      case (o)
         2'b00: r = v / d;
         2'b01: r = (v * d) % (longint'(1) << W);
         2'b10: begin
            if (x[W-1]) begin
               sv = v - (longint'(1) << W);
               r  = -((-sv + d - 1) / d);
            end else begin
               r = v / d;
            end
         end
         default: r = ((v << W) + v) / d;
      endcase
      return W'(r);
   endfunction

   function automatic int ref_lat(input int m, input int step);
      return (m + step - 1) / step;
   endfunction

`ifdef SEQ_SHIFTER_STATUS_EN
   function automatic logic ref_c(input logic [W-1:0] x, input int m, input logic [1:0] o);
      if (m == 0) return 1'b0;
      if (o == 2'b01) return x[W-m];
      return x[m-1];
   endfunction
`endif

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0 || in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
         bad++;
         $display("FAIL release: out_valid=%b/%b in_ready=%b/%b, want 0/0 1/1",
                  out_valid1, out_valid4, in_ready1, in_ready4);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input int tm, input logic [1:0] to, input bit rel);
      int lat1, lat4, cyc;
      logic [W-1:0] exp;
      exp = ref_q(ta, tm, to);
      @(negedge clk);
      total++;
      if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
         bad++;
         $display("FAIL ready_before_accept: in_ready=%b/%b want 1/1", in_ready1, in_ready4);
      end
      in_valid = 1'b1; a = ta; mag = MW'(tm); op = to;
      @(negedge clk);
      in_valid = 1'b0; a = W'($urandom); mag = MW'($urandom); op = 2'($urandom);
      lat1 = -1; lat4 = -1; cyc = 0;
      while ((lat1 < 0 || lat4 < 0) && cyc < 40) begin
         if (lat1 < 0 && out_valid1) lat1 = cyc;
         if (lat4 < 0 && out_valid4) lat4 = cyc;
         if (lat1 < 0 || lat4 < 0) begin
            @(negedge clk);
            cyc++;
         end
      end
      total++;
      if (lat1 != ref_lat(tm, 1)) begin
         bad++;
         $display("FAIL latency_step1 a=%h mag=%0d op=%0d: got %0d want %0d", ta, tm, to, lat1, ref_lat(tm, 1));
      end
      total++;
      if (lat4 != ref_lat(tm, 4)) begin
         bad++;
         $display("FAIL latency_step4 a=%h mag=%0d op=%0d: got %0d want %0d", ta, tm, to, lat4, ref_lat(tm, 4));
      end
      total++;
      if (q1 !== exp) begin
         bad++;
         $display("FAIL q_step1 a=%h mag=%0d op=%0d: got %h want %h", ta, tm, to, q1, exp);
      end
      total++;
      if (q4 !== exp) begin
         bad++;
         $display("FAIL q_step4 a=%h mag=%0d op=%0d: got %h want %h", ta, tm, to, q4, exp);
      end
`ifdef SEQ_SHIFTER_STATUS_EN
      total++;
      if (c1 !== ref_c(ta, tm, to) || c4 !== ref_c(ta, tm, to) || z1 !== (exp == '0) || z4 !== (exp == '0)) begin
         bad++;
         $display("FAIL flags a=%h mag=%0d op=%0d: C=%b/%b Z=%b/%b want C=%b Z=%b",
                  ta, tm, to, c1, c4, z1, z4, ref_c(ta, tm, to), (exp == '0));
      end
`endif
      if (rel) release_result();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (q1 !== '0 || q4 !== '0 || out_valid1 !== 1'b0 || out_valid4 !== 1'b0 ||
          in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
         bad++;
         $display("FAIL reset: q=%h/%h out_valid=%b/%b in_ready=%b/%b want 0000 0 1",
                  q1, q4, out_valid1, out_valid4, in_ready1, in_ready4);
      end
      rst = 1'b0;
   endtask

   task automatic test_srl_sweep();
      for (int m = 0; m < W; m++) run_op(16'h8000, m, 2'b00, 1'b1);
   endtask

   task automatic test_directed();
      logic [W-1:0] va [6] = '{16'h8000, 16'h8000, 16'h1111, 16'h1010, 16'h0001, 16'h8000};
      int           vm [6] = '{4, 4, 15, 1, 1, 15};
      logic [1:0]   vo [6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
      logic [W-1:0] vq [6] = '{16'hF800, 16'h0800, 16'h8000, 16'h0808, 16'h8000, 16'h0001};
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vm[i], vo[i], 1'b0);
         total++;
         if (q1 !== vq[i] || q4 !== vq[i]) begin
            bad++;
            $display("FAIL directed_%0d: got %h/%h want %h", i, q1, q4, vq[i]);
         end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] h1, h4;
      run_op(16'h1234, 5, 2'b11, 1'b0);
      h1 = q1; h4 = q4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = W'($urandom); mag = 4'd3; op = 2'b00;
         total++;
         if (q1 !== h1 || q4 !== h4 || out_valid1 !== 1'b1 || out_valid4 !== 1'b1 ||
             in_ready1 !== 1'b0 || in_ready4 !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: q=%h/%h out_valid=%b/%b in_ready=%b/%b want %h/%h 1 0",
                     i, q1, q4, out_valid1, out_valid4, in_ready1, in_ready4, h1, h4);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      total++;
      if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1 || out_valid1 !== 1'b0 || out_valid4 !== 1'b0 ||
          q1 !== h1 || q4 !== h4) begin
         bad++;
         $display("FAIL pop_no_accept: in_ready=%b/%b out_valid=%b/%b q=%h/%h want 1 0 %h/%h",
                  in_ready1, in_ready4, out_valid1, out_valid4, q1, q4, h1, h4);
      end
      run_op(16'hC3A5, 7, 2'b10, 1'b1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid = 1'b1; a = 16'hABCD; mag = 4'd10; op = 2'b00;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (q1 !== '0 || q4 !== '0 || out_valid1 !== 1'b0 || out_valid4 !== 1'b0 ||
          in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid: q=%h/%h out_valid=%b/%b in_ready=%b/%b want 0000 0 1",
                  q1, q4, out_valid1, out_valid4, in_ready1, in_ready4);
      end
      run_op(16'h0F0F, 10, 2'b01, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_op(W'($urandom), int'($urandom_range(0, W - 1)), 2'($urandom), 1'b1);
   endtask

   initial begin
      test_reset();
      test_srl_sweep();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
